// File: rtl/mem_dma_pkg.sv
// Shared types and constants for the memory DMA master: FSM state encoding,
// word stride and the fixed I/O port addresses of the responder map.
package mem_dma_pkg;
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN} dma_state_t;

    localparam int          WORD_BYTES   = 4;
    localparam logic [31:0] INPORT0_ADDR = 32'h0000FFF8;
    localparam logic [31:0] INPORT1_ADDR = 32'h0000FFF8 + 32'd4;
    localparam logic [31:0] OUTPORT_ADDR = 32'h0000FFFC;
endpackage

// File: rtl/dma_addr_gen.sv
// Loadable address register that advances by one word when stepped.
// Wraps modulo 2^WIDTH, so a block may legally run past the top of memory.
module dma_addr_gen
    import mem_dma_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             step,
    output logic [WIDTH-1:0] addr
);
    logic [WIDTH-1:0] addr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg <= '0;
        end else if (load) begin
            addr_reg <= load_value;
        end else if (step) begin
            addr_reg <= addr_reg + WIDTH'(WORD_BYTES);
        end
    end

    assign addr = addr_reg;
endmodule

// File: rtl/mem_dma_master.sv
// Bus initiator that copies (read src, write dst) or fills a block of words
// on the shared memory/IO interface; outputs are decoded from the FSM state.
module mem_dma_master
    import mem_dma_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] src_addr,
    input  logic [WIDTH-1:0] dst_addr,
    input  logic             src_inc,
    input  logic             dst_inc,
    input  logic [LEN_W-1:0] len,
    input  logic [WIDTH-1:0] fill_data,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] words_done,
    output logic [WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_wr_data,
    output logic             mem_write,
    input  logic [WIDTH-1:0] mem_rd_data
);
    dma_state_t       state_reg, state_next;
    logic             err_reg, err_next;
    logic             mode_reg;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] words_done_reg;
    logic [WIDTH-1:0] fill_reg;
    logic [WIDTH-1:0] data_reg;
    logic [1:0]       inc_reg;
    logic             misaligned;
    logic             load;
    logic             last_word;

    // Channel 0 is the source pointer, channel 1 the destination pointer.
    logic [1:0][WIDTH-1:0] base_addr;
    logic [1:0][WIDTH-1:0] cur_addr;
    logic [1:0]            inc_in;
    logic [1:0]            chan_step;

    assign base_addr = {dst_addr, src_addr};
    assign inc_in    = {dst_inc, src_inc};

    // Fill never reads, so only the destination must be aligned there.
    assign misaligned = ((!mode) && (src_addr[1:0] != 2'b00)) || (dst_addr[1:0] != 2'b00);
    assign load       = (state_reg == IDLE) && start && !misaligned;
    assign last_word  = (words_done_reg + LEN_W'(1)) == len_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            assign chan_step[gi] = (state_reg == WR) && inc_reg[gi];

            dma_addr_gen #(.WIDTH(WIDTH)) u_addr (
                .clk        (clk),
                .rst        (rst),
                .load       (load),
                .load_value (base_addr[gi]),
                .step       (chan_step[gi]),
                .addr       (cur_addr[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (misaligned) begin
                        err_next = 1'b1;
                    end else if (len == '0) begin
                        state_next = FIN;
                    end else begin
                        state_next = mode ? WR : RD;
                    end
                end
            end
            RD: begin
                if (abort) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else begin
                    state_next = CAP;
                end
            end
            CAP: begin
                if (abort) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else begin
                    state_next = WR;
                end
            end
            WR: begin
                // Finishing the last word takes priority over a coincident abort.
                if (last_word) begin
                    state_next = FIN;
                end else if (abort) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else begin
                    state_next = mode_reg ? WR : RD;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            err_reg        <= 1'b0;
            mode_reg       <= 1'b0;
            len_reg        <= '0;
            fill_reg       <= '0;
            data_reg       <= '0;
            inc_reg        <= 2'b00;
            words_done_reg <= '0;
        end else begin
            state_reg <= state_next;
            err_reg   <= err_next;
            if (load) begin
                mode_reg       <= mode;
                len_reg        <= len;
                fill_reg       <= fill_data;
                inc_reg        <= inc_in;
                words_done_reg <= '0;
            end
            if (state_reg == CAP) begin
                data_reg <= mem_rd_data;
            end
            if (state_reg == WR) begin
                words_done_reg <= words_done_reg + LEN_W'(1);
            end
        end
    end

    always_comb begin
        mem_address = '0;
        mem_wr_data = '0;
        mem_write   = 1'b0;
        case (state_reg)
            RD, CAP: mem_address = cur_addr[0];
            WR: begin
                mem_address = cur_addr[1];
                mem_wr_data = mode_reg ? fill_reg : data_reg;
                mem_write   = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy       = (state_reg != IDLE);
    assign done       = (state_reg == FIN);
    assign err        = err_reg;
    assign words_done = words_done_reg;
endmodule

// File: tb/tb_mem_dma_master.sv
// Bench for mem_dma_master paired with a small memory/IO responder model;
// directed scenarios followed by randomized transfers against an array model.
module tb_mem_dma_master;
    import mem_dma_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, mode = 1'b0, src_inc = 1'b0, dst_inc = 1'b0, abort = 1'b0;
    logic [31:0] src_addr = '0, dst_addr = '0, fill_data = '0;
    logic [15:0] len = '0;
    logic        busy, done, err, mem_write;
    logic [15:0] words_done;
    logic [31:0] mem_address, mem_wr_data, mem_rd_data;

    logic [31:0] ram [0:4095];
    logic [31:0] inport0 = '0, inport1 = '0, outport;
    logic        pre_we = 1'b0;
    logic [11:0] pre_idx = '0;
    logic [31:0] pre_data = '0;
    int          wr_total = 0, nonout_writes = 0;
    int          checks = 0, failures = 0;
    logic [31:0] model [0:127];

    always #5 clk = ~clk;

    mem_dma_master #(.WIDTH(32), .LEN_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .src_inc     (src_inc),
        .dst_inc     (dst_inc),
        .len         (len),
        .fill_data   (fill_data),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .words_done  (words_done),
        .mem_address (mem_address),
        .mem_wr_data (mem_wr_data),
        .mem_write   (mem_write),
        .mem_rd_data (mem_rd_data)
    );

    // Responder: synchronous read (data valid the cycle after the address), write on the edge.
    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_idx] <= pre_data;
        end else if (mem_write) begin
            wr_total <= wr_total + 1;
            if (mem_address == OUTPORT_ADDR) outport <= mem_wr_data;
            else begin
                nonout_writes <= nonout_writes + 1;
                ram[mem_address[13:2]] <= mem_wr_data;
            end
        end
        if (mem_address == INPORT0_ADDR)      mem_rd_data <= inport0;
        else if (mem_address == INPORT1_ADDR) mem_rd_data <= inport1;
        else                                  mem_rd_data <= ram[mem_address[13:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [11:0] idx, input logic [31:0] val);
        pre_idx  = idx;
        pre_data = val;
        pre_we   = 1'b1;
        step();
        pre_we   = 1'b0;
    endtask

    // Returns in the first cycle after the accepting edge.
    task automatic start_xfer(input logic m, input logic [31:0] s, input logic [31:0] d,
                              input logic si, input logic di, input logic [15:0] l,
                              input logic [31:0] f);
        mode = m; src_addr = s; dst_addr = d; src_inc = si; dst_inc = di;
        len = l; fill_data = f; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // cycles = 1 in the first cycle after the accepting edge.
    task automatic wait_end(input int max_cycles, output int cycles, output logic got_done,
                            output logic got_err, output logic saw_busy);
        cycles = 1;
        saw_busy = 1'b0;
        while (!done && !err && cycles <= max_cycles) begin
            if (busy) saw_busy = 1'b1;
            step();
            cycles++;
        end
        if (busy) saw_busy = 1'b1;
        got_done = done;
        got_err  = err;
    endtask

    initial begin
        int   cyc, w0, n0, seen;
        logic gd, ge, sb;

        // Reset state
        step();
        step();
        check("rst_ctrl", {28'd0, busy, done, err, mem_write}, 32'd0);
        check("rst_words", 32'(words_done), 32'd0);
        check("rst_addr", mem_address, 32'd0);
        check("rst_wdata", mem_wr_data, 32'd0);
        rst = 1'b0;
        step();

        // Copy of four words
        for (int i = 0; i < 4; i++) poke(12'(16 + i), 32'(i + 1));
        w0 = wr_total;
        start_xfer(1'b0, 32'h40, 32'h80, 1'b1, 1'b1, 16'd4, 32'd0);
        check("copy_rd_addr", mem_address, 32'h40);
        check("copy_rd_nowrite", 32'(mem_write), 32'd0);
        wait_end(60, cyc, gd, ge, sb);
        check("copy_latency", 32'(cyc), 32'd13);
        check("copy_done", 32'(gd), 32'd1);
        check("copy_words", 32'(words_done), 32'd4);
        check("copy_writes", 32'(wr_total - w0), 32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("copy_ram[%0d]", i), ram[32 + i], 32'(i + 1));
        step();
        check("copy_idle", {30'd0, busy, done}, 32'd0);

        // Fill of three words
        w0 = wr_total;
        start_xfer(1'b1, 32'd0, 32'h100, 1'b1, 1'b1, 16'd3, 32'hDEADBEEF);
        check("fill_first_wr", {31'd0, mem_write}, 32'd1);
        check("fill_first_addr", mem_address, 32'h100);
        wait_end(20, cyc, gd, ge, sb);
        check("fill_latency", 32'(cyc), 32'd4);
        check("fill_writes", 32'(wr_total - w0), 32'd3);
        for (int i = 0; i < 3; i++) check($sformatf("fill_ram[%0d]", i), ram[64 + i], 32'hDEADBEEF);
        step();

        // IO stream: INPORT0 to OUTPORT, both pointers fixed
        inport0 = 32'h1234;
        inport1 = 32'h5555;
        w0 = wr_total;
        n0 = nonout_writes;
        start_xfer(1'b0, INPORT0_ADDR, OUTPORT_ADDR, 1'b0, 1'b0, 16'd2, 32'd0);
        wait_end(30, cyc, gd, ge, sb);
        check("io_done", 32'(gd), 32'd1);
        check("io_outport", outport, 32'h1234);
        check("io_writes", 32'(wr_total - w0), 32'd2);
        check("io_stray_writes", 32'(nonout_writes - n0), 32'd0);
        step();

        // Misaligned destination
        w0 = wr_total;
        start_xfer(1'b0, 32'h40, 32'h82, 1'b1, 1'b1, 16'd4, 32'd0);
        wait_end(5, cyc, gd, ge, sb);
        check("mis_err", {30'd0, ge, gd}, 32'd2);
        check("mis_latency", 32'(cyc), 32'd1);
        check("mis_busy", 32'(sb), 32'd0);
        step();
        check("mis_err_pulse", {30'd0, err, busy}, 32'd0);
        check("mis_writes", 32'(wr_total - w0), 32'd0);

        // Zero-length transfer
        w0 = wr_total;
        start_xfer(1'b0, 32'h40, 32'h80, 1'b1, 1'b1, 16'd0, 32'd0);
        wait_end(5, cyc, gd, ge, sb);
        check("len0_done", {30'd0, gd, ge}, 32'd2);
        check("len0_latency", 32'(cyc), 32'd1);
        check("len0_busy_fin", 32'(sb), 32'd1);
        step();
        check("len0_writes", 32'(wr_total - w0), 32'd0);

        // Abort during the third write of an eight-word copy
        w0 = wr_total;
        start_xfer(1'b0, 32'h40, 32'h500, 1'b0, 1'b1, 16'd8, 32'd0);
        seen = 0;
        cyc = 0;
        while (seen < 3 && cyc < 40) begin
            if (mem_write) seen++;
            if (seen < 3) begin
                step();
                cyc++;
            end
        end
        check("abort_reach_wr3", 32'(seen), 32'd3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_flags", {29'd0, err, done, busy}, 32'd4);
        check("abort_words", 32'(words_done), 32'd3);
        repeat (5) step();
        check("abort_writes", 32'(wr_total - w0), 32'd3);
        check("abort_err_pulse", 32'(err), 32'd0);

        // New transfer accepted after abort
        start_xfer(1'b1, 32'd0, 32'h300, 1'b1, 1'b1, 16'd2, 32'hCAFE);
        wait_end(10, cyc, gd, ge, sb);
        check("post_abort_latency", 32'(cyc), 32'd3);
        check("post_abort_ram", ram[12'h0C1], 32'hCAFE);
        step();

        // Abort coinciding with the final write: completion wins
        start_xfer(1'b1, 32'd0, 32'h310, 1'b1, 1'b1, 16'd2, 32'h77);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_last_flags", {30'd0, done, err}, 32'd2);
        check("abort_last_words", 32'(words_done), 32'd2);
        step();

        // Destination wraps past the top of the address space
        start_xfer(1'b1, 32'd0, 32'hFFFFFFF8, 1'b1, 1'b1, 16'd3, 32'hA5A5A5A5);
        step();
        step();
        check("wrap_addr", mem_address, 32'd0);
        wait_end(10, cyc, gd, ge, sb);
        check("wrap_done", 32'(gd), 32'd1);
        check("wrap_ram_top", ram[12'hFFF], 32'hA5A5A5A5);
        check("wrap_ram_zero", ram[0], 32'hA5A5A5A5);
        step();

        // Asynchronous reset during the second RD of a copy
        start_xfer(1'b0, 32'h40, 32'h400, 1'b1, 1'b1, 16'd4, 32'd0);
        step();
        step();
        step();
        check("rstmid_words_before", 32'(words_done), 32'd1);
        check("rstmid_rd_addr", mem_address, 32'h44);
        #2 rst = 1'b1;
        #1;
        check("rstmid_ctrl", {28'd0, busy, done, err, mem_write}, 32'd0);
        check("rstmid_addr", mem_address, 32'd0);
        check("rstmid_words", 32'(words_done), 32'd0);
        #3 rst = 1'b0;
        step();
        check("rstmid_after", {15'd0, busy, words_done}, 32'd0);

        // Randomized transfers against an array model of the low RAM region
        for (int i = 0; i < 128; i++) begin
            model[i] = $urandom;
            poke(12'(i), model[i]);
        end
        for (int t = 0; t < 12; t++) begin
            logic        m, si, di;
            int          l, sbase, dbase;
            logic [31:0] f;
            m     = 1'($urandom_range(0, 1));
            si    = 1'($urandom_range(0, 1));
            di    = 1'($urandom_range(0, 1));
            l     = $urandom_range(1, 6);
            sbase = 4 * $urandom_range(0, 120);
            dbase = 4 * $urandom_range(0, 120);
            f     = $urandom;
            for (int i = 0; i < l; i++) begin
                int s, d;
                s = sbase + (si ? 4 * i : 0);
                d = dbase + (di ? 4 * i : 0);
                model[d / 4] = m ? f : model[s / 4];
            end
            w0 = wr_total;
            start_xfer(m, 32'(sbase), 32'(dbase), si, di, 16'(l), f);
            wait_end(40, cyc, gd, ge, sb);
            check($sformatf("rnd%0d_done", t), 32'(gd), 32'd1);
            check($sformatf("rnd%0d_cycles", t), 32'(cyc), 32'(m ? l + 1 : 3 * l + 1));
            check($sformatf("rnd%0d_words", t), 32'(words_done), 32'(l));
            check($sformatf("rnd%0d_writes", t), 32'(wr_total - w0), 32'(l));
            step();
            for (int i = 0; i < 128; i++) check($sformatf("rnd%0d_ram[%0d]", t, i), ram[i], model[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
